// File: rtl/odo_pkg.sv
// Shared encodings for the odometer frequency-difference controller.
package odo_pkg;

    // Operating mode as presented on the mode input.
    typedef enum logic [1:0] {
        ODO_IDLE   = 2'b00,
        ODO_STRESS = 2'b01,
        ODO_MEAS   = 2'b10,
        ODO_CONT   = 2'b11
    } odo_mode_e;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCount,
        StResult
    } odo_state_e;

    // Cycles spent flushing the synchronisers after the channel mux switches.
    localparam int unsigned SETTLE_CYCLES = 3;

endpackage

// File: rtl/odo_edge_counter.sv
// Synchronises an asynchronous ring-oscillator output, detects its rising
// edges and counts them into a saturating counter.
module odo_edge_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic             sync1_q, sync2_q, prev_q;
    logic             rise;
    logic [CNT_W-1:0] count_q, count_d;

    assign rise  = sync2_q & ~prev_q;
    assign count = count_q;
    assign sat   = (count_q == {CNT_W{1'b1}});

    // Next count: clear wins over counting; hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && rise && !sat) begin
            count_d = count_q + 1'b1;
        end
    end

    // Two-flop synchroniser, edge-detect history and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= ro;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/odo_freq_diff_ctrl.sv
// Odometer controller: drives stress enables to a ring-oscillator array and
// measures the frequency difference between a reference/stressed RO pair.
module odo_freq_diff_ctrl
    import odo_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TIMER  = 100,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  ODO_SEL_MUX,
    input  logic              start,
    input  logic [NUM_CH-1:0] ref_ro,
    input  logic [NUM_CH-1:0] str_ro,
    output logic [NUM_CH-1:0] stress_en,
    output logic              busy,
    output logic [CNT_W-1:0]  freq_diff,
    output logic              diff_sign,
    output logic              diff_valid,
    output logic              sat
);

    // One cycle counter serves both the settle and the count phase.
    localparam int unsigned CYC_W = (TIMER > 4) ? $clog2(TIMER) : 2;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] COUNT_LAST  = CYC_W'(TIMER - 1);

    odo_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] stress_en_q, onehot_sel;
    logic [CNT_W-1:0]  freq_diff_q, diff_d;
    logic              diff_sign_q, sign_d, diff_valid_q, sat_q;
    logic              meas_mode, sel_ok, cnt_clr, cnt_en, res_load;
    logic              ref_mux, str_mux;
    logic [CNT_W-1:0]  ref_cnt, str_cnt;
    logic              ref_sat, str_sat;

    assign meas_mode  = (mode == ODO_MEAS) || (mode == ODO_CONT);
    assign sel_ok     = (32'(ODO_SEL_MUX) < NUM_CH);
    assign busy       = (state_q != StIdle);
    assign stress_en  = stress_en_q;
    assign freq_diff  = freq_diff_q;
    assign diff_sign  = diff_sign_q;
    assign diff_valid = diff_valid_q;
    assign sat        = sat_q;

    // Channel mux on the latched select and one-hot decode of the live select.
    always_comb begin
        ref_mux    = 1'b0;
        str_mux    = 1'b0;
        onehot_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (sel_q == SEL_W'(i)) begin
                ref_mux = ref_ro[i];
                str_mux = str_ro[i];
            end
            onehot_sel[i] = (ODO_SEL_MUX == SEL_W'(i));
        end
    end

    odo_edge_counter #(
        .CNT_W (CNT_W)
    ) u_ref_cnt (
        .clk   (clk),
        .rst   (rst),
        .ro    (ref_mux),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (ref_cnt),
        .sat   (ref_sat)
    );

    odo_edge_counter #(
        .CNT_W (CNT_W)
    ) u_str_cnt (
        .clk   (clk),
        .rst   (rst),
        .ro    (str_mux),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (str_cnt),
        .sat   (str_sat)
    );

    // Magnitude and sign of the count difference; equal counts report positive zero.
    always_comb begin
        diff_d = ref_cnt - str_cnt;
        sign_d = 1'b0;
        if (str_cnt > ref_cnt) begin
            diff_d = str_cnt - ref_cnt;
            sign_d = 1'b1;
        end
    end

    // Sequencer next-state: settle, count window, one result cycle.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        sel_d    = sel_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        res_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && meas_mode && sel_ok) begin
                    state_d = StSettle;
                    sel_d   = ODO_SEL_MUX;
                    cyc_d   = '0;
                end
            end
            StSettle: begin
                cnt_clr = 1'b1;
                cyc_d   = cyc_q + 1'b1;
                if (cyc_q == SETTLE_LAST) begin
                    state_d = StCount;
                    cyc_d   = '0;
                end
            end
            StCount: begin
                cnt_en = 1'b1;
                cyc_d  = cyc_q + 1'b1;
                if (cyc_q == COUNT_LAST) begin
                    state_d = StResult;
                    cyc_d   = '0;
                end
            end
            StResult: begin
                res_load = 1'b1;
                cyc_d    = '0;
                state_d  = (mode == ODO_CONT) ? StSettle : StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Leaving a measuring mode abandons the window without publishing it.
        if (state_q != StIdle && !meas_mode) begin
            state_d  = StIdle;
            cyc_d    = '0;
            res_load = 1'b0;
        end
    end

    // State, latched channel, stress enables and published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            sel_q        <= '0;
            stress_en_q  <= '0;
            freq_diff_q  <= '0;
            diff_sign_q  <= 1'b0;
            diff_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            sel_q        <= sel_d;
            diff_valid_q <= res_load;
            stress_en_q  <= (mode == ODO_STRESS && state_q == StIdle) ? onehot_sel : '0;
            if (res_load) begin
                freq_diff_q <= diff_d;
                diff_sign_q <= sign_d;
                sat_q       <= ref_sat | str_sat;
            end
        end
    end

endmodule

// File: tb/tb_odo_freq_diff_ctrl.sv
// Scoreboard bench for odo_freq_diff_ctrl: an 8-bit instance for the main
// function and a 4-bit-counter instance for saturation.
module tb_odo_freq_diff_ctrl;

    typedef struct {
        int fd;
        int sg;
        int st;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] sel = 4'd0;
    logic       start = 1'b0;
    logic [1:0] mode_b = 2'b00;
    logic [3:0] sel_b = 4'd0;
    logic       start_b = 1'b0;
    logic [7:0] ref_ro = '0;
    logic [7:0] str_ro = '0;
    logic [7:0] str_b = '0;

    logic [7:0] stress_en, stress_en_b;
    logic       busy, busy_b;
    logic [7:0] freq_diff;
    logic [3:0] freq_diff_b;
    logic       diff_sign, diff_sign_b, diff_valid, diff_valid_b, sat, sat_b;

    int   per_ref[8] = '{default: 0};
    int   per_str[8] = '{default: 0};
    int   burst_on = 0;
    int   burst_t0 = 0;
    int   pcyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_main[$];
    exp_t q_sat[$];

    odo_freq_diff_ctrl #(
        .NUM_CH (8),
        .CNT_W  (8),
        .TIMER  (100),
        .SEL_W  (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .ODO_SEL_MUX (sel),
        .start       (start),
        .ref_ro      (ref_ro),
        .str_ro      (str_ro),
        .stress_en   (stress_en),
        .busy        (busy),
        .freq_diff   (freq_diff),
        .diff_sign   (diff_sign),
        .diff_valid  (diff_valid),
        .sat         (sat)
    );

    odo_freq_diff_ctrl #(
        .NUM_CH (8),
        .CNT_W  (4),
        .TIMER  (100),
        .SEL_W  (4)
    ) u_dut_sat (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode_b),
        .ODO_SEL_MUX (sel_b),
        .start       (start_b),
        .ref_ro      (ref_ro),
        .str_ro      (str_b),
        .stress_en   (stress_en_b),
        .busy        (busy_b),
        .freq_diff   (freq_diff_b),
        .diff_sign   (diff_sign_b),
        .diff_valid  (diff_valid_b),
        .sat         (sat_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Free-running square-wave ROs, plus a gated burst of exactly 12 rising edges.
    always @(negedge clk) begin
        for (int c = 0; c < 8; c++) begin
            ref_ro[c] <= (per_ref[c] != 0) && ((pcyc % per_ref[c]) >= per_ref[c] / 2);
            str_ro[c] <= (per_str[c] != 0) && ((pcyc % per_str[c]) >= per_str[c] / 2);
        end
        str_b    <= '0;
        str_b[1] <= (burst_on != 0) && (pcyc >= burst_t0) && (pcyc - burst_t0 < 96) &&
                    (((pcyc - burst_t0) % 8) >= 6);
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Main instance: every result pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && diff_valid) begin
            if (q_main.size() == 0) begin
                check_eq("main_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_main.pop_front();
                check_eq("main_freq_diff", int'(freq_diff), e.fd);
                check_eq("main_diff_sign", int'(diff_sign), e.sg);
                check_eq("main_sat", int'(sat), e.st);
                check_eq("main_valid_cycle", pcyc, e.cyc);
            end
        end
    end

    // Saturation instance scoreboard.
    always @(negedge clk) begin
        if (!rst && diff_valid_b) begin
            if (q_sat.size() == 0) begin
                check_eq("sat_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_sat.pop_front();
                check_eq("sat_freq_diff", int'(freq_diff_b), e.fd);
                check_eq("sat_diff_sign", int'(diff_sign_b), e.sg);
                check_eq("sat_sat", int'(sat_b), e.st);
                check_eq("sat_valid_cycle", pcyc, e.cyc);
            end
        end
    end

    // Pulse start on the main instance; returns the cycle number of the sampling edge.
    task automatic start_main(input int sel_v, output int s_cyc);
        @(negedge clk);
        sel   = 4'(sel_v);
        start = 1'b1;
        s_cyc = pcyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_main(input int fd, input int sg, input int st, input int cyc);
        exp_t e;
        e.fd = fd; e.sg = sg; e.st = st; e.cyc = cyc;
        q_main.push_back(e);
    endtask

    task automatic wait_queues(input int limit, input int budget);
        int n = 0;
        while ((q_main.size() + q_sat.size()) > limit && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check_eq("scoreboard_timeout", q_main.size() + q_sat.size(), limit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        exp_t e;
        per_ref[3] = 10; per_str[3] = 20;
        per_ref[0] = 20; per_str[0] = 10;
        per_ref[6] = 4;  per_str[6] = 4;
        per_ref[1] = 4;

        repeat (4) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_freq_diff", int'(freq_diff), 0);
        check_eq("rst_diff_sign", int'(diff_sign), 0);
        check_eq("rst_diff_valid", int'(diff_valid), 0);
        check_eq("rst_sat", int'(sat), 0);
        check_eq("rst_stress_en", int'(stress_en), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Stress enables follow the live select; out-of-range select gives none.
        mode = 2'b01; sel = 4'd5;
        @(negedge clk);
        check_eq("stress_sel5", int'(stress_en), 32'h20);
        sel = 4'd9;
        @(negedge clk);
        check_eq("stress_sel9", int'(stress_en), 0);
        mode = 2'b10;
        start_main(9, s);
        check_eq("start_bad_sel_busy", int'(busy), 0);

        // Single window on channel 3; a select change and start mid-window are ignored.
        start_main(3, s);
        push_main(10 - 5, 0, 0, s + 104);
        check_eq("single_busy", int'(busy), 1);
        repeat (48) @(negedge clk);
        start_main(6, s);
        wait_queues(0, 200);
        repeat (3) @(negedge clk);
        check_eq("single_idle_after", int'(busy), 0);

        // Equal counts report zero with positive sign.
        start_main(6, s);
        push_main(0, 0, 0, s + 104);
        wait_queues(0, 200);

        // Continuous windows on channel 0; switch to single during the third window.
        mode = 2'b11;
        start_main(0, s);
        for (int k = 1; k <= 3; k++) push_main(10 - 5, 1, 0, s + 104 * k);
        wait_queues(1, 400);
        mode = 2'b10;
        wait_queues(0, 200);
        repeat (3) @(negedge clk);
        check_eq("cont_idle_after", int'(busy), 0);

        // Abort by leaving measure mode at cycle 50 of the window.
        start_main(3, s);
        repeat (48) @(negedge clk);
        check_eq("abort_busy_before", int'(busy), 1);
        mode = 2'b00;
        @(negedge clk);
        check_eq("abort_busy_after", int'(busy), 0);
        repeat (120) @(negedge clk);
        check_eq("abort_freq_diff_held", int'(freq_diff), 5);
        check_eq("abort_diff_sign_held", int'(diff_sign), 1);

        // Reset in the middle of a window clears all outputs.
        mode = 2'b10;
        start_main(3, s);
        repeat (58) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_freq_diff", int'(freq_diff), 0);
        check_eq("midrst_diff_sign", int'(diff_sign), 0);
        check_eq("midrst_sat", int'(sat), 0);
        repeat (120) @(negedge clk);
        check_eq("midrst_still_idle", int'(busy), 0);
        mode = 2'b00;

        // 4-bit counters: ref saturates at 15, stressed burst gives 12.
        @(negedge clk);
        mode_b   = 2'b10;
        sel_b    = 4'd1;
        start_b  = 1'b1;
        burst_t0 = pcyc + 1;
        burst_on = 1;
        e.fd = 15 - 12; e.sg = 0; e.st = 1; e.cyc = pcyc + 1 + 104;
        q_sat.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        wait_queues(0, 200);

        repeat (5) @(negedge clk);
        check_eq("main_queue_drained", q_main.size(), 0);
        check_eq("sat_queue_drained", q_sat.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
